// File: rtl/mor1kx_spram_arbiter.sv
// mor1kx_spram_arbiter
// Shares one write-first single-port RAM between two requesters (A and B)
// using a same-cycle req/gnt handshake. Ties are resolved either by fixed
// priority (A wins) or round-robin. A built-in clear sequencer zero-fills
// every RAM word after reset and on request, so hardware never relies on
// simulation-only memory initialisation.

module mor1kx_spram_arbiter #(
  parameter int ADDR_WIDTH     = 6,
  parameter int DATA_WIDTH     = 32,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter bit FIXED_PRIO     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  clear_done,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam state_t                RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // last_q: 0 = A was granted most recently, 1 = B was
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  last_q, last_d;
  logic                  a_rvalid_q, a_rvalid_d;
  logic                  b_rvalid_q, b_rvalid_d;
  logic                  clear_done_q, clear_done_d;

  logic                  a_gnt_c, b_gnt_c;
  logic                  ram_en_c, ram_we_c;
  logic [ADDR_WIDTH-1:0] ram_addr_c;
  logic [DATA_WIDTH-1:0] ram_din_c;

  // Next-state, arbitration and RAM port muxing
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    last_d       = last_q;
    clear_done_d = 1'b0;
    a_gnt_c      = 1'b0;
    b_gnt_c      = 1'b0;
    ram_en_c     = 1'b0;
    ram_we_c     = 1'b0;
    ram_addr_c   = '0;
    ram_din_c    = '0;

    case (state_q)
      ST_CLEAR: begin
        ram_en_c   = 1'b1;
        ram_we_c   = 1'b1;
        ram_addr_c = clr_cnt_q;
        clr_cnt_d  = clr_cnt_q + CNT_ONE;
        if (clr_cnt_q == '1) begin
          state_d      = ST_RUN;
          clear_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (a_req && b_req) begin
          if (FIXED_PRIO || last_q) a_gnt_c = 1'b1;
          else                      b_gnt_c = 1'b1;
        end else begin
          a_gnt_c = a_req;
          b_gnt_c = b_req;
        end
        if (a_gnt_c) begin
          ram_en_c   = 1'b1;
          ram_we_c   = a_we;
          ram_addr_c = a_addr;
          ram_din_c  = a_din;
          last_d     = 1'b0;
        end else if (b_gnt_c) begin
          ram_en_c   = 1'b1;
          ram_we_c   = b_we;
          ram_addr_c = b_addr;
          ram_din_c  = b_din;
          last_d     = 1'b1;
        end
        if (clear_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: state_d = RESET_STATE;
    endcase

    a_rvalid_d = a_gnt_c && !a_we;
    b_rvalid_d = b_gnt_c && !b_we;
  end

  // State, clear counter, arbitration history and read-valid pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RESET_STATE;
      clr_cnt_q    <= '0;
      last_q       <= 1'b1;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      last_q       <= last_d;
      a_rvalid_q   <= a_rvalid_d;
      b_rvalid_q   <= b_rvalid_d;
      clear_done_q <= clear_done_d;
    end
  end

  // Grants and RAM strobes are forced low while reset is held
  always_comb begin
    a_gnt      = a_gnt_c && rst_n;
    b_gnt      = b_gnt_c && rst_n;
    ram_en     = ram_en_c && rst_n;
    ram_we     = ram_we_c && rst_n;
    ram_addr   = ram_addr_c;
    ram_din    = ram_din_c;
    busy       = (state_q == ST_CLEAR);
    clear_done = clear_done_q;
    a_rvalid   = a_rvalid_q;
    b_rvalid   = b_rvalid_q;
    rdata      = ram_dout;
  end

endmodule

// File: tb/tb_mor1kx_spram_arbiter.sv
// Testbench for mor1kx_spram_arbiter
// Two instances share the same stimulus: one round-robin, one fixed-priority.
// Each drives its own behavioural write-first RAM.

module tb_mor1kx_spram_arbiter;

  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, a_we, b_req, b_we, clear_req;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_din, b_din;

  logic          rr_a_gnt, rr_a_rvalid, rr_b_gnt, rr_b_rvalid, rr_busy, rr_clear_done;
  logic          rr_ram_en, rr_ram_we;
  logic [AW-1:0] rr_ram_addr;
  logic [DW-1:0] rr_ram_din, rr_ram_dout, rr_rdata;

  logic          fx_a_gnt, fx_a_rvalid, fx_b_gnt, fx_b_rvalid, fx_busy, fx_clear_done;
  logic          fx_ram_en, fx_ram_we;
  logic [AW-1:0] fx_ram_addr;
  logic [DW-1:0] fx_ram_din, fx_ram_dout, fx_rdata;

  logic [DW-1:0] rr_mem [1<<AW];
  logic [DW-1:0] fx_mem [1<<AW];

  int checks = 0;
  int errors = 0;

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  mor1kx_spram_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_ON_RESET(1'b1), .FIXED_PRIO(1'b0)
  ) u_rr (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_gnt(rr_a_gnt), .a_rvalid(rr_a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_gnt(rr_b_gnt), .b_rvalid(rr_b_rvalid),
    .rdata(rr_rdata), .clear_req(clear_req), .busy(rr_busy), .clear_done(rr_clear_done),
    .ram_en(rr_ram_en), .ram_we(rr_ram_we), .ram_addr(rr_ram_addr),
    .ram_din(rr_ram_din), .ram_dout(rr_ram_dout)
  );

  mor1kx_spram_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_ON_RESET(1'b1), .FIXED_PRIO(1'b1)
  ) u_fx (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_gnt(fx_a_gnt), .a_rvalid(fx_a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_gnt(fx_b_gnt), .b_rvalid(fx_b_rvalid),
    .rdata(fx_rdata), .clear_req(clear_req), .busy(fx_busy), .clear_done(fx_clear_done),
    .ram_en(fx_ram_en), .ram_we(fx_ram_we), .ram_addr(fx_ram_addr),
    .ram_din(fx_ram_din), .ram_dout(fx_ram_dout)
  );

  // Behavioural write-first RAMs, preloaded with a non-zero pattern
  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      rr_mem[i] = 32'hA5A5_A5A5;
      fx_mem[i] = 32'hA5A5_A5A5;
    end
    rr_ram_dout = '0;
    fx_ram_dout = '0;
  end

  always @(posedge clk) begin
    if (rr_ram_en) begin
      if (rr_ram_we) begin
        rr_mem[rr_ram_addr] <= rr_ram_din;
        rr_ram_dout         <= rr_ram_din;
      end else begin
        rr_ram_dout <= rr_mem[rr_ram_addr];
      end
    end
    if (fx_ram_en) begin
      if (fx_ram_we) begin
        fx_mem[fx_ram_addr] <= fx_ram_din;
        fx_ram_dout         <= fx_ram_din;
      end else begin
        fx_ram_dout <= fx_mem[fx_ram_addr];
      end
    end
  end

  // Drive one cycle of inputs on the falling edge, then let logic settle
  task automatic applyStimulus(input logic ar, input logic awe, input logic [AW-1:0] aad,
                               input logic [DW-1:0] ad, input logic br, input logic bwe,
                               input logic [AW-1:0] bad, input logic [DW-1:0] bd,
                               input logic clr);
    @(negedge clk);
    a_req = ar;  a_we = awe;  a_addr = aad;  a_din = ad;
    b_req = br;  b_we = bwe;  b_addr = bad;  b_din = bd;
    clear_req = clr;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Directed sequence
  initial begin
    rst_n = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_din = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_din = '0;
    clear_req = 1'b0;
    #1;

    // 1: reset values, then a full clear of 16 words
    $display("[TB] reset and power-on clear");
    checkOutput("rst_busy", {31'b0, rr_busy}, 32'd1);
    checkOutput("rst_ram_en", {31'b0, rr_ram_en}, 32'd0);
    checkOutput("rst_a_gnt", {31'b0, rr_a_gnt}, 32'd0);
    checkOutput("rst_a_rvalid", {31'b0, rr_a_rvalid}, 32'd0);
    checkOutput("rst_clear_done", {31'b0, rr_clear_done}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    b_req = 1'b1;
    #1;
    checkOutput("clr_b_gnt_blocked", {31'b0, rr_b_gnt}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) idle();
      checkOutput("clr_en", {31'b0, rr_ram_en}, 32'd1);
      checkOutput("clr_we", {31'b0, rr_ram_we}, 32'd1);
      checkOutput("clr_addr", {28'b0, rr_ram_addr}, i);
      checkOutput("clr_din", rr_ram_din, 32'd0);
      checkOutput("clr_busy", {31'b0, rr_busy}, 32'd1);
    end
    applyStimulus(1'b1, 1'b0, 4'd5, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("clr_done_pulse", {31'b0, rr_clear_done}, 32'd1);
    checkOutput("run_busy", {31'b0, rr_busy}, 32'd0);
    checkOutput("rd5_a_gnt", {31'b0, rr_a_gnt}, 32'd1);
    idle();
    checkOutput("clr_done_single", {31'b0, rr_clear_done}, 32'd0);
    checkOutput("rd5_a_rvalid", {31'b0, rr_a_rvalid}, 32'd1);
    checkOutput("rd5_rdata", rr_rdata, 32'd0);

    // 2: A writes, B reads the same address
    $display("[TB] write then read by other port");
    applyStimulus(1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("wr3_a_gnt", {31'b0, rr_a_gnt}, 32'd1);
    checkOutput("wr3_ram_we", {31'b0, rr_ram_we}, 32'd1);
    checkOutput("wr3_ram_addr", {28'b0, rr_ram_addr}, 32'd3);
    checkOutput("wr3_ram_din", rr_ram_din, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'd3, '0, 1'b0);
    checkOutput("rd3_b_gnt", {31'b0, rr_b_gnt}, 32'd1);
    checkOutput("wr3_no_a_rvalid", {31'b0, rr_a_rvalid}, 32'd0);
    idle();
    checkOutput("rd3_b_rvalid", {31'b0, rr_b_rvalid}, 32'd1);
    checkOutput("rd3_a_rvalid", {31'b0, rr_a_rvalid}, 32'd0);
    checkOutput("rd3_rdata", rr_rdata, 32'hDEAD_BEEF);

    // 3+4: both request reads every cycle (A addr 3, B addr 5)
    $display("[TB] contention, round-robin and fixed priority");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 4'd3, '0, 1'b1, 1'b0, 4'd5, '0, 1'b0);
      checkOutput("rr_a_gnt", {31'b0, rr_a_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput("rr_b_gnt", {31'b0, rr_b_gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
      checkOutput("fx_a_gnt", {31'b0, fx_a_gnt}, 32'd1);
      checkOutput("fx_b_gnt", {31'b0, fx_b_gnt}, 32'd0);
      if (i > 0) begin
        checkOutput("rr_a_rvalid", {31'b0, rr_a_rvalid}, (i % 2 == 1) ? 32'd1 : 32'd0);
        checkOutput("rr_b_rvalid", {31'b0, rr_b_rvalid}, (i % 2 == 0) ? 32'd1 : 32'd0);
        checkOutput("rr_rdata", rr_rdata, (i % 2 == 1) ? 32'hDEAD_BEEF : 32'd0);
      end
    end
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'd5, '0, 1'b0);
    checkOutput("fx_b_gnt_after_a_drop", {31'b0, fx_b_gnt}, 32'd1);
    checkOutput("rr_b_gnt_alone", {31'b0, rr_b_gnt}, 32'd1);

    // 5: read in the same cycle as clear_req, then clear
    $display("[TB] clear request with concurrent read");
    applyStimulus(1'b1, 1'b1, 4'd7, 32'h0000_1234, 1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd7, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    checkOutput("clrreq_a_gnt", {31'b0, rr_a_gnt}, 32'd1);
    checkOutput("clrreq_busy_same", {31'b0, rr_busy}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      idle();
      if (i == 0) begin
        checkOutput("clrreq_a_rvalid", {31'b0, rr_a_rvalid}, 32'd1);
        checkOutput("clrreq_rdata", rr_rdata, 32'h0000_1234);
      end
      checkOutput("clr2_busy", {31'b0, rr_busy}, 32'd1);
      checkOutput("clr2_addr", {28'b0, rr_ram_addr}, i);
    end
    applyStimulus(1'b1, 1'b0, 4'd7, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("clr2_done", {31'b0, rr_clear_done}, 32'd1);
    idle();
    checkOutput("rd7_after_clear", rr_rdata, 32'd0);
    checkOutput("fx_rd7_after_clear", fx_rdata, 32'd0);

    // 6: reset in the middle of a clear
    $display("[TB] reset during clear");
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      idle();
      checkOutput("clr3_addr", {28'b0, rr_ram_addr}, i);
    end
    @(negedge clk);
    a_req = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ram_en", {31'b0, rr_ram_en}, 32'd0);
    checkOutput("midrst_a_gnt", {31'b0, rr_a_gnt}, 32'd0);
    checkOutput("midrst_busy", {31'b0, rr_busy}, 32'd1);
    @(negedge clk);
    a_req = 1'b0;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) idle();
      checkOutput("clr4_en", {31'b0, rr_ram_en}, 32'd1);
      checkOutput("clr4_addr", {28'b0, rr_ram_addr}, i);
    end
    idle();
    checkOutput("clr4_done", {31'b0, rr_clear_done}, 32'd1);

    // Pending read-valid is dropped by reset
    $display("[TB] reset drops pending rvalid");
    applyStimulus(1'b1, 1'b0, 4'd3, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    idle();
    checkOutput("pend_a_rvalid", {31'b0, rr_a_rvalid}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("pend_dropped", {31'b0, rr_a_rvalid}, 32'd0);
    checkOutput("pend_busy", {31'b0, rr_busy}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
